// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance-counter snapshot reader.
// Optional read-and-clear behaviour is enabled with PERF_SNAP_CLEAR_EN.
package perf_pkg;

  localparam int PERF_NUM_CNT = 4;
  localparam int PERF_CNT_W   = 4;
  // Widest counter bus the slice helper accepts; counters up to 32 bits each.
  localparam int PERF_BUS_W   = 256;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } perf_state_e;

  // Returns counter i (width w) of a packed bus, right-aligned in 32 bits.
  function automatic logic [31:0] cnt_slice(input logic [PERF_BUS_W-1:0] bus,
                                            input int w, input int i);
    return 32'(bus >> (i * w));
  endfunction

endpackage

// File: rtl/perf_shadow_bank.sv
// Capture registers for one snapshot of the counter bank, with an indexed read port.
// Built as part of perf_snapshot_reader (see PERF_SNAP_CLEAR_EN there).
module perf_shadow_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT = PERF_NUM_CNT,
  parameter int CNT_W   = PERF_CNT_W,
  parameter int IDX_W   = $clog2(NUM_CNT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [CNT_W-1:0]         rd_data
);

  logic [CNT_W-1:0] shadow_word [NUM_CNT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_slot
      logic [CNT_W-1:0] value_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          value_reg <= '0;
        end else if (load) begin
          value_reg <= CNT_W'(cnt_slice(PERF_BUS_W'(cnt_in), CNT_W, gi));
        end
      end

      assign shadow_word[gi] = value_reg;
    end
  endgenerate

  // Out-of-range indices (non power-of-two banks) read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_CNT) begin
      rd_data = shadow_word[rd_idx];
    end
  end

endmodule

// File: rtl/perf_snapshot_reader.sv
// Snapshots the counter bank on request and streams the values out one per beat.
// Define PERF_SNAP_CLEAR_EN to pulse clr_out once per accepted snapshot.
module perf_snapshot_reader
  import perf_pkg::*;
#(
  parameter int NUM_CNT = PERF_NUM_CNT,
  parameter int CNT_W   = PERF_CNT_W,
  parameter int IDX_W   = $clog2(NUM_CNT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     snap_req,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  output logic                     clr_out,
  output logic                     busy,
  output logic                     snap_overrun,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CNT_W-1:0]         m_data,
  output logic [IDX_W-1:0]         m_idx,
  output logic                     m_last
);

  perf_state_e      state_reg, state_next;
  logic             m_valid_reg, m_valid_next;
  logic [CNT_W-1:0] m_data_reg, m_data_next;
  logic [IDX_W-1:0] m_idx_reg, m_idx_next;
  logic             m_last_reg, m_last_next;
  logic             overrun_reg;
  logic             accept;
  logic             handshake;
  logic [IDX_W-1:0] idx_plus;
  logic [CNT_W-1:0] rd_data;

  assign accept    = snap_req && (state_reg == ST_IDLE);
  assign handshake = m_valid_reg && m_ready;
  assign idx_plus  = m_idx_reg + IDX_W'(1);

  // The bank is read one index ahead so the next beat's data can be registered.
  perf_shadow_bank #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .cnt_in  (cnt_in),
    .rd_idx  (idx_plus),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next   = state_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_idx_next   = m_idx_reg;
    m_last_next  = m_last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (snap_req) begin
          // The shadow bank loads at this same edge, so beat 0 comes straight from cnt_in.
          state_next   = ST_SEND;
          m_valid_next = 1'b1;
          m_idx_next   = '0;
          m_data_next  = CNT_W'(cnt_slice(PERF_BUS_W'(cnt_in), CNT_W, 0));
          m_last_next  = 1'b0;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (m_last_reg) begin
            state_next   = ST_IDLE;
            m_valid_next = 1'b0;
            m_idx_next   = '0;
            m_last_next  = 1'b0;
          end else begin
            m_idx_next   = idx_plus;
            m_data_next  = rd_data;
            m_last_next  = (idx_plus == IDX_W'(NUM_CNT - 1));
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        m_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_idx_reg   <= '0;
      m_last_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      m_idx_reg   <= m_idx_next;
      m_last_reg  <= m_last_next;
      if (snap_req && (state_reg == ST_SEND)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

`ifdef PERF_SNAP_CLEAR_EN
  logic clr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_reg <= 1'b0;
    end else begin
      clr_reg <= accept;
    end
  end

  assign clr_out = clr_reg;
`else
  assign clr_out = 1'b0;
`endif

  assign busy         = (state_reg == ST_SEND);
  assign snap_overrun = overrun_reg;
  assign m_valid      = m_valid_reg;
  assign m_data       = m_data_reg;
  assign m_idx        = m_idx_reg;
  assign m_last       = m_last_reg;

endmodule

// File: tb/tb_perf_snapshot_reader.sv
// Randomized and directed bench for perf_snapshot_reader against a queue-based model.
// Honours PERF_SNAP_CLEAR_EN when predicting clr_out.
module tb_perf_snapshot_reader;

  localparam int NUM_CNT = 4;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 2;
  localparam int BUS_W   = NUM_CNT * CNT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             snap_req;
  logic [BUS_W-1:0] cnt_in;
  logic             clr_out;
  logic             busy;
  logic             snap_overrun;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_data;
  logic [IDX_W-1:0] m_idx;
  logic             m_last;

  int checks = 0;
  int errors = 0;

  // Model: values still to be delivered, in delivery order.
  int  exp_q[$];
  int  sent_m;
  bit  overrun_m;
  bit  clr_m;
  bit  data_zero_m;

  always #5 clk = ~clk;

  perf_snapshot_reader #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .snap_req     (snap_req),
    .cnt_in       (cnt_in),
    .clr_out      (clr_out),
    .busy         (busy),
    .snap_overrun (snap_overrun),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_idx        (m_idx),
    .m_last       (m_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic sr, input logic rdy,
                            input logic [BUS_W-1:0] cin);
    clr_m = 1'b0;
    if (rst) begin
      exp_q.delete();
      sent_m      = 0;
      overrun_m   = 1'b0;
      data_zero_m = 1'b1;
    end else if (exp_q.size() == 0) begin
      if (sr) begin
        for (int i = 0; i < NUM_CNT; i++) exp_q.push_back(int'((cin >> (i * CNT_W)) & 16'hF));
        sent_m      = 0;
        data_zero_m = 1'b0;
`ifdef PERF_SNAP_CLEAR_EN
        clr_m       = 1'b1;
`endif
        $display("snap  capture cnt_in=%04h", cin);
      end
    end else begin
      if (sr) overrun_m = 1'b1;
      if (rdy) begin
        $display("beat  idx=%0d data=%0d last=%0d", sent_m, exp_q[0], exp_q.size() == 1);
        void'(exp_q.pop_front());
        sent_m++;
      end
    end
  endtask

  task automatic compare_all();
    bit act;
    act = (exp_q.size() != 0);
    chk("busy", 32'(busy), 32'(act));
    chk("m_valid", 32'(m_valid), 32'(act));
    chk("snap_overrun", 32'(snap_overrun), 32'(overrun_m));
    chk("clr_out", 32'(clr_out), 32'(clr_m));
    if (act) begin
      chk("m_idx", 32'(m_idx), 32'(sent_m));
      chk("m_data", 32'(m_data), 32'(exp_q[0]));
      chk("m_last", 32'(m_last), 32'(exp_q.size() == 1));
    end else begin
      chk("m_idx_idle", 32'(m_idx), 32'd0);
      chk("m_last_idle", 32'(m_last), 32'd0);
      if (data_zero_m) chk("m_data_reset", 32'(m_data), 32'd0);
    end
  endtask

  task automatic step(input logic rst, input logic sr, input logic rdy,
                      input logic [BUS_W-1:0] cin);
    reset    = rst;
    snap_req = sr;
    m_ready  = rdy;
    cnt_in   = cin;
    @(posedge clk);
    model_edge(rst, sr, rdy, cin);
    #1;
    compare_all();
  endtask

  initial begin
    logic [BUS_W-1:0] pat;
    pat = {4'd9, 4'd3, 4'd15, 4'd1};
    reset = 1'b1; snap_req = 1'b0; m_ready = 1'b0; cnt_in = '0;
    exp_q.delete(); sent_m = 0; overrun_m = 1'b0; clr_m = 1'b0; data_zero_m = 1'b1;

    // Reset state
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(0, 0, 1, pat);

    // Full-rate stream
    step(0, 1, 1, pat);
    for (int i = 0; i < 5; i++) step(0, 0, 1, pat);

    // Stalled first beat while the live counters change
    step(0, 1, 0, pat);
    for (int i = 0; i < 3; i++) step(0, 0, 0, {4{4'd7}});
    for (int i = 0; i < 5; i++) step(0, 0, 1, {4{4'd7}});

    // Dropped request at T+2, accepted one at T+5
    step(0, 1, 1, pat);
    step(0, 0, 1, pat);
    step(0, 1, 1, 16'h5A5A);
    step(0, 0, 1, pat);
    step(0, 1, 1, pat);
    step(0, 1, 1, 16'h2468);
    for (int i = 0; i < 5; i++) step(0, 0, 1, pat);

    // Reset while beat idx 2 is presented, then a fresh stream
    step(0, 1, 1, pat);
    step(0, 0, 1, pat);
    step(0, 0, 1, pat);
    step(1, 0, 1, pat);
    step(0, 0, 1, pat);
    step(0, 1, 1, 16'hC0DE);
    for (int i = 0; i < 5; i++) step(0, 0, 1, pat);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) < 7), BUS_W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
